// File: rtl/output_stream_packer.sv
// ============================================================================
// Module   : output_stream_packer
// Purpose  : Buffers 64-bit engine output words in a FIFO and serializes each
//            word into two 32-bit beats (low half first) on a valid/ready
//            stream. Reports occupancy, sticky overflow and dropped words.
// Options  : OUTPUT_PACKER_DROP_CNT_EN - when defined, drop_cnt counts dropped
//            words (saturating); otherwise drop_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_stream_packer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [3:0]       out_strb,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             overflow,
  output logic [15:0]      drop_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] cnt;
  logic             ph;
  logic             ovf;

  logic             beat;
  logic             pop_entry;
  logic             push;
  logic             drop;
  logic             not_full;

  // Handshake qualification: a full FIFO may still accept a word when the
  // final beat of the head entry leaves in the same cycle. clear wins.
  always_comb begin
    not_full  = (cnt < DEPTH_CNT);
    beat      = out_valid && out_ready;
    pop_entry = beat && ph;
    push      = in_valid && !clear && (not_full || pop_entry);
    drop      = in_valid && !clear && !push;
  end

  // Output view is derived from registered state only (no path from out_ready).
  always_comb begin
    out_valid = (cnt != '0);
    out_data  = '0;
    if (out_valid) begin
      out_data = ph ? mem[rp][63:32] : mem[rp][31:0];
    end
    out_strb  = out_valid ? 4'hF : 4'h0;
    in_ready  = not_full;
    count     = cnt;
    empty     = (cnt == '0);
    overflow  = ovf;
  end

  // Storage array write; contents are only observed while cnt > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= in_data;
    end
  end

  // Pointers, occupancy, beat phase and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ph  <= 1'b0;
      ovf <= 1'b0;
    end else if (clear) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ph  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + PTR_W'(1);
      end
      if (pop_entry) begin
        rp <= rp + PTR_W'(1);
      end
      if (beat) begin
        ph <= ~ph;
      end
      case ({push, pop_entry})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef OUTPUT_PACKER_DROP_CNT_EN
  logic [15:0] drops;

  // Saturating count of words lost because the FIFO was full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drops <= '0;
    end else if (clear) begin
      drops <= '0;
    end else if (drop && (drops != 16'hFFFF)) begin
      drops <= drops + 16'd1;
    end
  end

  assign drop_cnt = drops;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_output_stream_packer.sv
// ============================================================================
// Module   : tb_output_stream_packer
// Purpose  : Self-checking bench for output_stream_packer; a scoreboard queue
//            of pushed words supplies the expected beat sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_stream_packer;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef OUTPUT_PACKER_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic             in_valid;
  logic [63:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic [3:0]       out_strb;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             overflow;
  logic [15:0]      drop_cnt;

  output_stream_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_strb(out_strb),
    .out_ready(out_ready), .count(count), .empty(empty),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference state
  logic [63:0] q[$];
  logic        mph  = 1'b0;
  logic        movf = 1'b0;
  logic [15:0] mdrop = 16'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mph   = 1'b0;
    movf  = 1'b0;
    mdrop = 16'h0;
  endtask

  // Called at a falling edge: check visible state, account for the coming
  // rising edge in the model, then advance to the next falling edge.
  task automatic step();
    int  n;
    bit  beat;
    bit  pop;
    bit  push;
    logic [31:0] exp_beat;
    n = q.size();
    chk("count", 64'(count), 64'(n));
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("out_strb", 64'(out_strb), (n != 0) ? 64'hF : 64'h0);
    chk("empty", 64'(empty), 64'(n == 0));
    chk("in_ready", 64'(in_ready), 64'(n < DEPTH));
    chk("overflow", 64'(overflow), 64'(movf));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    if (clear) begin
      model_reset();
    end else begin
      beat = (n != 0) && out_ready;
      pop  = beat && mph;
      push = in_valid && ((n < DEPTH) || pop);
      if (beat) begin
        exp_beat = mph ? q[0][63:32] : q[0][31:0];
        chk("beat_data", 64'(out_data), 64'(exp_beat));
        if (mph) void'(q.pop_front());
        mph = ~mph;
      end
      if (push) begin
        q.push_back(in_data);
      end else if (in_valid) begin
        movf = 1'b1;
        if (DROP_EN && mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [63:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_strb", 64'(out_strb), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    reset = 1'b0;
    step();

    // Single word, sink always ready
    out_ready = 1'b1;
    push_word(64'h8877665544332211);
    chk("single_low", 64'(out_data), 64'h44332211);
    chk("single_cnt1", 64'(count), 64'h1);
    step();
    chk("single_high", 64'(out_data), 64'h88776655);
    chk("single_high_valid", 64'(out_valid), 64'h1);
    step();
    chk("single_cnt0", 64'(count), 64'h0);
    chk("single_empty", 64'(empty), 64'h1);

    // Backpressure hold, then gapless release
    out_ready = 1'b0;
    push_word(64'h8877665544332211);
    push_word(64'h1122334455667788);
    push_word(64'hA5A5A5A55A5A5A5A);
    for (int i = 0; i < 10; i++) step();
    chk("bp_hold_data", 64'(out_data), 64'h44332211);
    chk("bp_count", 64'(count), 64'h3);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_no_gap", 64'(out_valid), 64'h1);
      step();
    end
    chk("bp_drained", 64'(empty), 64'h1);

    // Overflow: ten words into an eight-deep FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word({32'(i) + 32'hC0DE0000, 32'(i) ^ 32'hFFFF0000});
    chk("ovf_count", 64'(count), 64'(DEPTH));
    chk("ovf_in_ready", 64'(in_ready), 64'h0);
    chk("ovf_flag", 64'(overflow), 64'h1);
    chk("ovf_drop_cnt", 64'(drop_cnt), DROP_EN ? 64'h2 : 64'h0);
    drain(2 * DEPTH + 2);
    chk("ovf_sticky", 64'(overflow), 64'h1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'h0);

    // Full FIFO with final beat leaving in the same cycle as a push
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word({$urandom, $urandom});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    step();
    chk("full_pending_high", 64'(count), 64'(DEPTH));
    out_ready = 1'b1;
    push_word(64'hFEEDFACE0BADF00D);
    chk("full_pop_push_cnt", 64'(count), 64'(DEPTH));
    chk("full_pop_push_ovf", 64'(overflow), 64'h0);
    drain(2 * DEPTH + 2);

    // Pointer wrap at one word per two cycles
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_word({$urandom, $urandom});
      chk("wrap_cnt_le1", 64'(count <= CNT_W'(1)), 64'h1);
      step();
      chk("wrap_cnt_le1", 64'(count <= CNT_W'(1)), 64'h1);
    end
    drain(3);

    // Clear mid-word after an overflow
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_word({$urandom, $urandom});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_out_valid", 64'(out_valid), 64'h0);
    chk("clr_count", 64'(count), 64'h0);
    chk("clr_overflow", 64'(overflow), 64'h0);
    chk("clr_drop_cnt", 64'(drop_cnt), 64'h0);
    out_ready = 1'b1;
    push_word(64'h0123456789ABCDEF);
    chk("clr_new_low", 64'(out_data), 64'h89ABCDEF);
    drain(3);

    // Asynchronous reset mid-word after an overflow
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_word({$urandom, $urandom});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'h0);
    chk("ar_count", 64'(count), 64'h0);
    chk("ar_overflow", 64'(overflow), 64'h0);
    chk("ar_drop_cnt", 64'(drop_cnt), 64'h0);
    model_reset();
    reset = 1'b0;
    out_ready = 1'b1;
    push_word(64'hCAFEBABEDEADBEEF);
    chk("ar_new_low", 64'(out_data), 64'hDEADBEEF);
    drain(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
